maxpool_wb: RTL

MAXPOOL_WB -- requirements
Module: maxpool_wb

---
 rtl/maxpool_wb_if.sv | 26 ++
 rtl/maxpool_wb.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/maxpool_wb_if.sv
// Stream port of the 2x2 max-pool writeback stage.
// The master drives pixels and start; the slave returns pooled memory writes.
interface maxpool_wb_if #(
    parameter int DATA_W = 16
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [15:0]              out_addr;
    logic                     plane_done;
    logic                     layer_done;

    modport master (
        output start, in_valid, in_data,
        input  out_valid, out_data, out_addr,
        input  plane_done, layer_done
    );

    modport slave (
        input  start, in_valid, in_data,
        output out_valid, out_data, out_addr,
        output plane_done, layer_done
    );
endinterface

// File: rtl/maxpool_wb.sv
// 2x2 stride-2 max-pool with optional ReLU over raster-order neuron results.
// Writes pooled results out as an address/data stream, plane after plane.
module maxpool_wb #(
    parameter int DATA_W     = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int NUM_PLANES = 6,
    parameter bit RELU_EN    = 1
) (
    input logic        clk,
    input logic        rst,
    maxpool_wb_if.slave bus
);
    localparam int HW  = IMG_W / 2;
    localparam int PSZ = HW * (IMG_H / 2);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int PW  = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
    localparam int LW  = (HW > 1) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t r_state, w_state_n;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [PW-1:0] r_plane;

    logic signed [DATA_W-1:0] r_h;
    logic signed [DATA_W-1:0] r_lb [HW];

    logic                     r_ov;
    logic signed [DATA_W-1:0] r_od;
    logic [15:0]              r_oa;
    logic                     r_pd;
    logic                     r_ld;

    logic                     w_acc;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_pl_last;
    logic                     w_last_px;
    logic                     w_last_all;
    logic                     w_emit;
    logic [LW-1:0]            w_lbi;
    logic signed [DATA_W-1:0] w_hmax;
    logic signed [DATA_W-1:0] w_vmax;
    logic signed [DATA_W-1:0] w_res;
    logic [15:0]              w_addr;

    function automatic logic signed [DATA_W-1:0] max2(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // start outranks a coincident pixel, which is dropped
    assign w_acc      = bus.in_valid && !bus.start &&
                        (r_state == S_ACTIVE);
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_pl_last  = (r_plane == PW'(NUM_PLANES - 1));
    assign w_last_px  = w_acc && w_col_last && w_row_last;
    assign w_last_all = w_last_px && w_pl_last;
    assign w_emit     = w_acc && r_col[0] && r_row[0];

    assign w_lbi  = LW'(r_col >> 1);
    assign w_hmax = max2(r_h, bus.in_data);
    assign w_vmax = max2(r_lb[w_lbi], w_hmax);
    assign w_res  = (RELU_EN && w_vmax[DATA_W-1]) ? '0 : w_vmax;
    assign w_addr = 16'(r_plane) * 16'(PSZ) +
                    16'(r_row >> 1) * 16'(HW) +
                    16'(w_lbi);

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.start) w_state_n = S_ACTIVE;
            S_ACTIVE: begin
                if (bus.start)       w_state_n = S_ACTIVE;
                else if (w_last_all) w_state_n = S_DONE;
            end
            S_DONE:   if (bus.start) w_state_n = S_ACTIVE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_plane <= '0;
        end else if (bus.start) begin
            r_col   <= '0;
            r_row   <= '0;
            r_plane <= '0;
        end else if (w_acc) begin
            r_col <= w_col_last ? '0 : r_col + CW'(1);
            if (w_col_last)
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            if (w_col_last && w_row_last)
                r_plane <= w_pl_last ? '0 : r_plane + PW'(1);
        end
    end

    // datapath storage is always written before it is read
    always_ff @(posedge clk) begin
        if (w_acc && !r_col[0])
            r_h <= bus.in_data;
        if (w_acc && r_col[0] && !r_row[0])
            r_lb[w_lbi] <= w_hmax;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov <= 1'b0;
            r_od <= '0;
            r_oa <= '0;
            r_pd <= 1'b0;
            r_ld <= 1'b0;
        end else begin
            r_ov <= w_emit;
            r_pd <= w_last_px;
            if (w_emit) begin
                r_od <= w_res;
                r_oa <= w_addr;
            end
            if (bus.start)       r_ld <= 1'b0;
            else if (w_last_all) r_ld <= 1'b1;
        end
    end

    assign bus.out_valid  = r_ov;
    assign bus.out_data   = r_od;
    assign bus.out_addr   = r_oa;
    assign bus.plane_done = r_pd;
    assign bus.layer_done = r_ld;
endmodule
